// File: rtl/hazard_pkg.sv
// hazard_pkg: forwarding select codes and MDU stall FSM state encoding shared by hazard_unit.
package hazard_pkg;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mdu_state_e;
endpackage

// File: rtl/mdu_stall_fsm.sv
// mdu_stall_fsm: holds a multi-cycle MDU op in E for MDU_LATENCY cycles, flagging the final one as done.
module mdu_stall_fsm
    import hazard_pkg::*;
#(
    parameter int MDU_LATENCY = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic mdu_stall,
    output logic mdu_done
);
    localparam int CW = (MDU_LATENCY > 2) ? $clog2(MDU_LATENCY - 1) : 1;
    mdu_state_e state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt <= cnt_nxt;
        end
    end
    // Outputs are forced low while reset is high even though state only clears at the edge.
    always_comb begin
        state_nxt = state;
        cnt_nxt = cnt;
        mdu_stall = 1'b0;
        mdu_done = 1'b0;
        if (!reset) begin
            if (state == IDLE) begin
                if (start) begin
                    mdu_stall = 1'b1;
                    state_nxt = BUSY;
                    cnt_nxt = CW'(MDU_LATENCY - 2);
                end
            end else if (cnt != '0) begin
                mdu_stall = 1'b1;
                cnt_nxt = cnt - CW'(1);
            end else begin
                mdu_done = 1'b1;
                state_nxt = IDLE;
            end
        end
    end
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: forwarding, load-use stall, branch flush and MDU stall control for the 5-stage core.
// Define HAZARD_PERF_CNT_EN to add saturating stall/flush cycle counters.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW      = 5,
`ifdef HAZARD_PERF_CNT_EN
    parameter int CNT_W       = 32,
`endif
    parameter int MDU_LATENCY = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs1D,
    input  logic [REG_AW-1:0] rs2D,
    input  logic [REG_AW-1:0] rs1E,
    input  logic [REG_AW-1:0] rs2E,
    input  logic [REG_AW-1:0] rdE,
    input  logic [REG_AW-1:0] rdM,
    input  logic [REG_AW-1:0] rdW,
    input  logic              regwriteM,
    input  logic              regwriteW,
    input  logic              loadE,
    input  logic              pcsrcE,
    input  logic              mdu_startE,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0]  stall_cyc,
    output logic [CNT_W-1:0]  flush_cyc,
`endif
    output logic              mdu_doneE
);
    logic lwstall, mdu_stall, branch;
    mdu_stall_fsm #(.MDU_LATENCY(MDU_LATENCY)) u_mdu (
        .clk(clk),
        .reset(reset),
        .start(mdu_startE),
        .mdu_stall(mdu_stall),
        .mdu_done(mdu_doneE)
    );
    // M is the younger producer, so it wins over W; x0 never forwards.
    assign forwardAE = reset ? FWD_RF : (regwriteM && |rdM && rdM == rs1E) ? FWD_MEM
                     : (regwriteW && |rdW && rdW == rs1E) ? FWD_WB : FWD_RF;
    assign forwardBE = reset ? FWD_RF : (regwriteM && |rdM && rdM == rs2E) ? FWD_MEM
                     : (regwriteW && |rdW && rdW == rs2E) ? FWD_WB : FWD_RF;
    assign lwstall = !reset && loadE && |rdE && (rdE == rs1D || rdE == rs2D);
    assign branch = !reset && pcsrcE;
    assign stallF = lwstall || mdu_stall;
    assign stallD = stallF;
    assign stallE = mdu_stall;
    assign flushD = branch && !mdu_stall;
    assign flushE = (lwstall || branch) && !mdu_stall;
    assign flushM = mdu_stall;
    assert property (@(posedge clk) disable iff (reset) $onehot0({pcsrcE, loadE, mdu_startE}));
`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cyc <= '0;
            flush_cyc <= '0;
        end else begin
            if (stallF && !(&stall_cyc)) stall_cyc <= stall_cyc + CNT_W'(1);
            if (flushE && !(&flush_cyc)) flush_cyc <= flush_cyc + CNT_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed and randomized checks of hazard_unit against an occupancy-based reference model.
module tb_hazard_unit;
    import hazard_pkg::*;
    localparam int AW = 5;
    localparam int LAT = 4;
    logic clk = 1'b0;
    logic reset;
    logic [AW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic regwriteM, regwriteW, loadE, pcsrcE, mdu_startE;
    logic [1:0] forwardAE, forwardBE;
    logic stallF, stallD, stallE, flushD, flushE, flushM, mdu_doneE;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cyc, flush_cyc;
`endif
    int vectors = 0;
    int miscompares = 0;
    int rem = 0;
    int m_stall = 0;
    int m_flush = 0;

    hazard_unit #(.REG_AW(AW), .MDU_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
        .rdE(rdE), .rdM(rdM), .rdW(rdW),
        .regwriteM(regwriteM), .regwriteW(regwriteW),
        .loadE(loadE), .pcsrcE(pcsrcE), .mdu_startE(mdu_startE),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .flushD(flushD), .flushE(flushE), .flushM(flushM),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cyc(stall_cyc), .flush_cyc(flush_cyc),
`endif
        .mdu_doneE(mdu_doneE)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic [AW-1:0] rs);
        if (regwriteM && rdM != 0 && rdM == rs) return 2'b10;
        if (regwriteW && rdW != 0 && rdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clear_inputs();
        {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = '0;
        {regwriteM, regwriteW, loadE, pcsrcE, mdu_startE} = '0;
    endtask

    // rem = cycles the current MDU op still occupies E, counting the present one.
    task automatic step(input string tag);
        logic lw, ms, dn, br;
        #1;
        lw = loadE && rdE != 0 && (rdE == rs1D || rdE == rs2D);
        ms = (rem == 0) ? mdu_startE : (rem > 1);
        dn = (rem == 1);
        br = pcsrcE;
        if (reset) {lw, ms, dn, br} = '0;
        chk({tag, ".fwd"}, {forwardAE, forwardBE}, reset ? 4'b0 : {fwd_ref(rs1E), fwd_ref(rs2E)});
        chk({tag, ".ctl"}, {stallF, stallD, stallE, flushD, flushE, flushM, mdu_doneE},
            {lw | ms, lw | ms, ms, br & !ms, (lw | br) & !ms, ms, dn});
`ifdef HAZARD_PERF_CNT_EN
        chk({tag, ".perf"}, {stall_cyc[15:0], flush_cyc[15:0]}, {16'(m_stall), 16'(m_flush)});
`endif
        @(posedge clk);
        if (reset) begin
            rem = 0;
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (lw | ms) m_stall++;
            if ((lw | br) & !ms) m_flush++;
            if (rem > 0) rem--;
            else if (mdu_startE) rem = LAT - 1;
        end
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        step("rst0");
        mdu_startE = 1'b1;
        rdM = 5; regwriteM = 1'b1; rs1E = 5;
        #1 chk("rst_fwd", {30'b0, forwardAE}, 32'b0);
        chk("rst_ctl", {stallF, stallE, flushM, mdu_doneE}, 4'b0);
        step("rst1");
        clear_inputs();
        reset = 1'b0;
        step("idle");

        rdM = 5; regwriteM = 1'b1; rdW = 5; regwriteW = 1'b1; rs1E = 5;
        #1 chk("fwd_mem", {30'b0, forwardAE}, 32'b10);
        step("fwd_mem");
        regwriteM = 1'b0;
        #1 chk("fwd_wb", {30'b0, forwardAE}, 32'b01);
        step("fwd_wb");
        regwriteM = 1'b1; rdM = 0; rdW = 0; rs1E = 0; rs2E = 0;
        #1 chk("fwd_x0", {forwardAE, forwardBE}, 4'b0);
        step("fwd_x0");
        clear_inputs();

        loadE = 1'b1; rdE = 7; rs2D = 7;
        #1 chk("lw_stall", {stallF, stallD, flushE, stallE}, 4'b1110);
        step("lw_stall");
        loadE = 1'b0;
        #1 chk("lw_clear", {stallF, stallD, flushE, stallE}, 4'b0);
        step("lw_clear");
        clear_inputs();

        pcsrcE = 1'b1;
        #1 chk("br_flush", {flushD, flushE, stallF, stallE}, 4'b1100);
        step("br_flush");
        pcsrcE = 1'b0;
        #1 chk("br_after", {flushD, flushE}, 2'b00);
        step("br_after");

        mdu_startE = 1'b1;
        for (int c = 0; c < LAT; c++) begin
            #1 chk($sformatf("mdu_c%0d", c), {stallE, flushM, mdu_doneE}, (c < LAT - 1) ? 3'b110 : 3'b001);
            step("mdu");
        end
        mdu_startE = 1'b0;
        #1 chk("mdu_idle", {stallE, flushM, mdu_doneE}, 3'b0);
        step("mdu_idle");

        mdu_startE = 1'b1;
        step("mdu_r0");
        reset = 1'b1;
        #1 chk("mdu_rst", {stallF, stallE, flushM, mdu_doneE}, 4'b0);
        step("mdu_rst");
        reset = 1'b0;
        mdu_startE = 1'b0;
        #1 chk("mdu_post", {stallF, stallE, flushM, mdu_doneE}, 4'b0);
        step("mdu_post");

        mdu_startE = 1'b1;
        for (int c = 0; c < LAT; c++) step("perf_mdu");
        mdu_startE = 1'b0;
        loadE = 1'b1; rdE = 3; rs1D = 3;
        step("perf_lw");
        clear_inputs();
        step("perf_end");
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_stall", stall_cyc, 32'd4);
        chk("perf_flush", flush_cyc, 32'd1);
`endif

        for (int i = 0; i < 3000; i++) begin
            int k;
            k = $urandom_range(0, 9);
            rs1D = AW'($urandom_range(0, 7));
            rs2D = AW'($urandom_range(0, 7));
            rs1E = AW'($urandom_range(0, 7));
            rs2E = AW'($urandom_range(0, 7));
            rdE = AW'($urandom_range(0, 7));
            rdM = AW'($urandom_range(0, 7));
            rdW = AW'($urandom_range(0, 7));
            regwriteM = 1'($urandom);
            regwriteW = 1'($urandom);
            loadE = (k == 1 || k == 2);
            pcsrcE = (k == 3);
            mdu_startE = (k == 4 || k == 5);
            reset = ($urandom_range(0, 59) == 0);
            step("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
